// File: rtl/fun_fpsu_cluster.sv
// Paired SIMD FP-side lane cluster: LANES pipelined 4x16-bit lanes with bypass, kill and occupancy.
// Optional build macro FPSU_OUT_REG_EN appends an output register stage (latency LAT+1).
module fun_fpsu_cluster #(
   parameter int LANES = 6,
   parameter int WIDTH = 68,
   parameter int LAT   = 2,
   parameter int RET_W = 14
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                fpcsr,
   input  logic [LANES*WIDTH-1:0]     u_A,
   input  logic [LANES*WIDTH-1:0]     u_B,
   input  logic [LANES*4-1:0]         u_en,
   input  logic [LANES*13-1:0]        u_op,
   input  logic [LANES*2-1:0]         u_fwd_A,
   input  logic [LANES*2-1:0]         u_fwd_B,
   input  logic [LANES-1:0]           u_kill,
   output logic [LANES*WIDTH-1:0]     u_res,
   output logic [LANES*RET_W-1:0]     u_ret,
   output logic [LANES-1:0]           u_ret_en,
   output logic [(LANES/2)*6-1:0]     FOOSL_out
);

`ifdef FPSU_OUT_REG_EN
   localparam int DEPTH = LAT + 1;
`else
   localparam int DEPTH = LAT;
`endif

   logic unused_csr;
   assign unused_csr = ^fpcsr[31:1];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int P = l ^ 1;

      logic             issue;
      logic             sgn;
      logic [3:0]       op;
      logic [3:0]       en;
      logic [WIDTH-1:0] own_tap, par_tap, a_sel, b_sel, res_c;
      logic [RET_W-1:0] ret_c;
      logic [DEPTH-1:0] v_q;
      logic [WIDTH-1:0] d_q [DEPTH];
      logic [RET_W-1:0] r_q [DEPTH];
      logic [2:0]       cnt;
      logic             unused_op;

      logic [15:0] ea, eb, er;
      logic [16:0] sum, dif;
      logic        ef, ovf_a, ovf_s, gt;

      assign unused_op = ^u_op[l*13+4 +: 9];
      assign op    = u_op[l*13 +: 4];
      assign en    = u_en[l*4 +: 4];
      assign sgn   = fpcsr[0];
      assign issue = |en;

      // A lane not presenting a result forwards zero rather than its held u_res.
      assign own_tap = u_ret_en[l] ? u_res[l*WIDTH +: WIDTH] : '0;
      assign par_tap = u_ret_en[P] ? u_res[P*WIDTH +: WIDTH] : '0;

      always_comb begin
         case (u_fwd_A[l*2 +: 2])
            2'b01:   a_sel = own_tap;
            2'b10:   a_sel = par_tap;
            default: a_sel = u_A[l*WIDTH +: WIDTH];
         endcase
         case (u_fwd_B[l*2 +: 2])
            2'b01:   b_sel = own_tap;
            2'b10:   b_sel = par_tap;
            default: b_sel = u_B[l*WIDTH +: WIDTH];
         endcase
      end

      always_comb begin
         res_c = '0;
         ret_c = '0;
         ea    = '0;
         eb    = '0;
         er    = '0;
         sum   = '0;
         dif   = '0;
         ef    = 1'b0;
         ovf_a = 1'b0;
         ovf_s = 1'b0;
         gt    = 1'b0;
         res_c[67:64] = a_sel[67:64] | b_sel[67:64];
         for (int e = 0; e < 4; e++) begin
            ea    = a_sel[16*e +: 16];
            eb    = b_sel[16*e +: 16];
            sum   = {1'b0, ea} + {1'b0, eb};
            dif   = {1'b0, ea} - {1'b0, eb};
            ovf_a = (ea[15] == eb[15]) && (sum[15] != ea[15]);
            ovf_s = (ea[15] != eb[15]) && (dif[15] != ea[15]);
            gt    = sgn ? ($signed(ea) > $signed(eb)) : (ea > eb);
            er    = ea;
            ef    = 1'b0;
            case (op)
               4'd0: begin
                  er = sum[15:0];
                  ef = sgn ? ovf_a : sum[16];
               end
               4'd1: begin
                  er = dif[15:0];
                  ef = sgn ? ovf_s : dif[16];
               end
               4'd2: er = ea & eb;
               4'd3: er = ea | eb;
               4'd4: er = ea ^ eb;
               4'd5: begin
                  if (sgn) begin
                     er = ovf_a ? (ea[15] ? 16'h8000 : 16'h7FFF) : sum[15:0];
                     ef = ovf_a;
                  end else begin
                     er = sum[16] ? 16'hFFFF : sum[15:0];
                     ef = sum[16];
                  end
               end
               4'd6: er = gt ? ea : eb;
               4'd7: er = gt ? eb : ea;
               4'd8: er = (ea == eb) ? 16'hFFFF : 16'h0000;
               default: er = ea;
            endcase
            if (en[e]) begin
               res_c[16*e +: 16] = er;
               ret_c[4+e]        = ef;
            end else begin
               res_c[16*e +: 16] = ea;
            end
         end
         if (op > 4'd8) begin
            res_c = '0;
            ret_c = '0;
            ret_c[3:0] = 4'h1;
         end
      end

      // Data registers load only with a valid op so the last stage holds u_res between results.
      always_ff @(posedge clk) begin
         if (!rst) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
               d_q[k] <= '0;
               r_q[k] <= '0;
            end
         end else begin
            v_q[0] <= issue;
            if (issue) begin
               d_q[0] <= res_c;
               r_q[0] <= ret_c;
            end
            for (int k = 1; k < DEPTH; k++) begin
               v_q[k] <= v_q[k-1] & ~u_kill[l];
               if (v_q[k-1] && !u_kill[l]) begin
                  d_q[k] <= d_q[k-1];
                  r_q[k] <= r_q[k-1];
               end
            end
         end
      end

      always_comb begin
         cnt = '0;
         for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + 3'(v_q[k]);
         end
      end

      assign u_res[l*WIDTH +: WIDTH] = d_q[DEPTH-1];
      assign u_ret[l*RET_W +: RET_W] = v_q[DEPTH-1] ? r_q[DEPTH-1] : '0;
      assign u_ret_en[l]             = v_q[DEPTH-1];
      assign FOOSL_out[l*3 +: 3]     = cnt;
   end

endmodule
